// File: rtl/axis_packet_arbiter_if.sv
// ============================================================================
// Module   : axis_if
// Brief    : AXI-Stream bundle used by axis_packet_arbiter (m = source, s = sink)
// Revision : 1.0
// ============================================================================
`default_nettype none

interface axis_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 4
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;
    logic [USER_WIDTH-1:0]   tuser;

    modport m (output tvalid, tdata, tkeep, tlast, tid, tdest, tuser, input tready);
    modport s (input tvalid, tdata, tkeep, tlast, tid, tdest, tuser, output tready);
endinterface

`default_nettype wire

// File: rtl/axis_packet_arbiter.sv
// ============================================================================
// Module   : axis_packet_arbiter
// Brief    : Packet-granular round-robin merge of CHANNEL_NUMBER AXIS inputs.
//            Optional per-input packet counters: define AXIS_ARB_PKT_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axis_packet_arbiter #(
    parameter int CHANNEL_NUMBER       = 5,
    parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
    parameter int DATA_WIDTH           = 32,
    parameter int ID_WIDTH             = 4,
    parameter int DEST_WIDTH           = 4,
    parameter int USER_WIDTH           = 4,
    parameter int CNT_WIDTH            = 16,
    parameter logic [ID_WIDTH-1:0] ROUTING_HEADER = '0
) (
    input  wire logic                            clk,
    input  wire logic                            rst,
    axis_if.s                                    in [CHANNEL_NUMBER],
    axis_if.m                                    out,
    output logic [CHANNEL_NUMBER_WIDTH-1:0]      grant_idx,
    output logic                                 grant_vld
`ifdef AXIS_ARB_PKT_CNT_EN
    ,
    output logic [CHANNEL_NUMBER-1:0][CNT_WIDTH-1:0] pkt_cnt
`endif
);

    localparam int CNW = CHANNEL_NUMBER_WIDTH;
    localparam int KW  = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                r_state, w_state_nx;
    logic [CNW-1:0]        r_gnt, w_gnt_nx;
    logic [CNW-1:0]        r_rr_ptr, w_rr_nx;

    logic                  w_vld  [CHANNEL_NUMBER];
    logic [DATA_WIDTH-1:0] w_data [CHANNEL_NUMBER];
    logic [KW-1:0]         w_keep [CHANNEL_NUMBER];
    logic                  w_lastv[CHANNEL_NUMBER];
    logic [ID_WIDTH-1:0]   w_tid  [CHANNEL_NUMBER];
    logic [DEST_WIDTH-1:0] w_dest [CHANNEL_NUMBER];
    logic [USER_WIDTH-1:0] w_user [CHANNEL_NUMBER];
    logic                  w_rdy  [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0] w_req;

    logic                  w_any_req;
    logic [CNW-1:0]        w_win;
    logic [CNW-1:0]        w_sel;
    logic                  w_fwd;
    logic                  w_hs;
    logic                  w_last;

    function automatic logic [CNW-1:0] f_inc(input logic [CNW-1:0] v);
        f_inc = (v == CNW'(CHANNEL_NUMBER - 1)) ? '0 : v + 1'b1;
    endfunction

    generate
        for (genvar g = 0; g < CHANNEL_NUMBER; g++) begin : g_in
            assign w_vld[g]    = in[g].tvalid;
            assign w_data[g]   = in[g].tdata;
            assign w_keep[g]   = in[g].tkeep;
            assign w_lastv[g]  = in[g].tlast;
            assign w_tid[g]    = in[g].tid;
            assign w_dest[g]   = in[g].tdest;
            assign w_user[g]   = in[g].tuser;
            assign w_req[g]    = in[g].tvalid && (in[g].tid == ROUTING_HEADER);
            assign in[g].tready = w_rdy[g];
        end
    endgenerate

    // Round-robin scan starting at r_rr_ptr, wrapping modulo CHANNEL_NUMBER.
    always_comb begin
        logic [CNW:0] idx;
        w_any_req = 1'b0;
        w_win     = '0;
        idx       = '0;
        for (int k = 0; k < CHANNEL_NUMBER; k++) begin
            idx = {1'b0, r_rr_ptr} + (CNW+1)'(k);
            if (idx >= (CNW+1)'(CHANNEL_NUMBER))
                idx = idx - (CNW+1)'(CHANNEL_NUMBER);
            if (!w_any_req && w_req[idx[CNW-1:0]]) begin
                w_any_req = 1'b1;
                w_win     = idx[CNW-1:0];
            end
        end
    end

    assign w_sel = (r_state == ST_IDLE) ? w_win : r_gnt;
    assign w_fwd = (r_state != ST_IDLE) || w_any_req;

    assign out.tvalid = w_fwd && w_vld[w_sel];
    assign out.tdata  = w_fwd ? w_data[w_sel]  : '0;
    assign out.tkeep  = w_fwd ? w_keep[w_sel]  : '0;
    assign out.tlast  = w_fwd ? w_lastv[w_sel] : 1'b0;
    assign out.tid    = w_fwd ? w_tid[w_sel]   : '0;
    assign out.tdest  = w_fwd ? w_dest[w_sel]  : '0;
    assign out.tuser  = w_fwd ? w_user[w_sel]  : '0;

    assign w_hs   = out.tvalid && out.tready;
    assign w_last = w_lastv[w_sel];

    always_comb begin
        for (int j = 0; j < CHANNEL_NUMBER; j++)
            w_rdy[j] = w_fwd && (w_sel == CNW'(j)) && out.tready;
    end

    assign grant_idx = w_sel;
    assign grant_vld = w_fwd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_gnt    <= w_gnt_nx;
            r_rr_ptr <= w_rr_nx;
        end
    end

    // An offered-but-stalled header moves to HOLD so the selected beat stays stable.
    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_rr_nx    = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_gnt_nx = w_win;
                    if (!w_hs)
                        w_state_nx = ST_HOLD;
                    else if (w_last)
                        w_rr_nx = f_inc(w_win);
                    else
                        w_state_nx = ST_LOCKED;
                end
            end
            ST_HOLD: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_state_nx = ST_IDLE;
                        w_rr_nx    = f_inc(r_gnt);
                    end else begin
                        w_state_nx = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_hs && w_last) begin
                    w_state_nx = ST_IDLE;
                    w_rr_nx    = f_inc(r_gnt);
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

`ifdef AXIS_ARB_PKT_CNT_EN
    logic [CNT_WIDTH-1:0] r_cnt [CHANNEL_NUMBER];

    generate
        for (genvar g = 0; g < CHANNEL_NUMBER; g++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst)
                    r_cnt[g] <= '0;
                else if (w_hs && w_last && (w_sel == CNW'(g)) && (r_cnt[g] != '1))
                    r_cnt[g] <= r_cnt[g] + 1'b1;
            end
            assign pkt_cnt[g] = r_cnt[g];
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_packet_arbiter.sv
// ============================================================================
// Module   : tb_axis_packet_arbiter
// Brief    : Directed + random bench for axis_packet_arbiter with a packet-level model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_axis_packet_arbiter;
    localparam int N   = 5;
    localparam int NW  = $clog2(N);
    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int IW  = 4;
    localparam int DSW = 4;
    localparam int UW  = 4;
    localparam int CW  = 16;
    localparam logic [IW-1:0] HDR = '0;

    typedef struct {
        logic [IW-1:0]  tid;
        logic [DW-1:0]  data;
        logic [KW-1:0]  keep;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
        logic           last;
    } beat_t;

    beat_t q [N][$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dn_rdy = 1'b0;

    logic           src_vld  [N];
    logic [IW-1:0]  src_tid  [N];
    logic [DW-1:0]  src_data [N];
    logic [KW-1:0]  src_keep [N];
    logic [DSW-1:0] src_dest [N];
    logic [UW-1:0]  src_user [N];
    logic           src_last [N];
    logic           rdy_obs  [N];

    logic [NW-1:0]  grant_idx;
    logic           grant_vld;
`ifdef AXIS_ARB_PKT_CNT_EN
    logic [N-1:0][CW-1:0] pkt_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int m_owner = -1;
    int m_rr    = 0;
    int m_cnt [N];

    always #5 clk = ~clk;

    axis_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) in_if [N] ();
    axis_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)) out_if ();

    generate
        for (genvar g = 0; g < N; g++) begin : g_src
            assign in_if[g].tvalid = src_vld[g];
            assign in_if[g].tid    = src_tid[g];
            assign in_if[g].tdata  = src_data[g];
            assign in_if[g].tkeep  = src_keep[g];
            assign in_if[g].tdest  = src_dest[g];
            assign in_if[g].tuser  = src_user[g];
            assign in_if[g].tlast  = src_last[g];
            assign rdy_obs[g]      = in_if[g].tready;
        end
    endgenerate

    assign out_if.tready = dn_rdy;

    axis_packet_arbiter #(
        .CHANNEL_NUMBER (N),
        .DATA_WIDTH     (DW),
        .ID_WIDTH       (IW),
        .DEST_WIDTH     (DSW),
        .USER_WIDTH     (UW),
        .CNT_WIDTH      (CW),
        .ROUTING_HEADER (HDR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_if),
        .out       (out_if),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
`ifdef AXIS_ARB_PKT_CNT_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int ch, input int len, input logic [IW-1:0] first_tid);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.tid  = (k == 0) ? first_tid : IW'($urandom_range(0, 15));
            b.data = $urandom;
            b.keep = KW'($urandom);
            b.dest = DSW'($urandom);
            b.user = UW'($urandom);
            b.last = (k == len - 1);
            q[ch].push_back(b);
        end
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < N; i++)
            if (q[i].size() > 0) p = 1;
        return p;
    endfunction

    // One clock: present queue heads, check outputs at negedge, advance model at posedge.
    task automatic cycle(input bit chk);
        int sel;
        bit act;
        bit hs;
        logic [N-1:0] e_rdy;
        logic [N-1:0] o_rdy;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                src_vld[i]  = 1'b1;
                src_tid[i]  = q[i][0].tid;
                src_data[i] = q[i][0].data;
                src_keep[i] = q[i][0].keep;
                src_dest[i] = q[i][0].dest;
                src_user[i] = q[i][0].user;
                src_last[i] = q[i][0].last;
            end else begin
                src_vld[i]  = 1'b0;
                src_tid[i]  = IW'($urandom);
                src_data[i] = $urandom;
                src_keep[i] = KW'($urandom);
                src_dest[i] = DSW'($urandom);
                src_user[i] = UW'($urandom);
                src_last[i] = 1'($urandom);
            end
        end
        @(negedge clk);
        sel = 0;
        act = 0;
        if (m_owner >= 0) begin
            sel = m_owner;
            act = 1;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (!act && src_vld[c] && src_tid[c] == HDR) begin
                    act = 1;
                    sel = c;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            e_rdy[i] = act && (i == sel) && dn_rdy;
            o_rdy[i] = rdy_obs[i];
        end
        hs = act && src_vld[sel] && dn_rdy;
        if (chk) begin
            check("tvalid",    out_if.tvalid, act && src_vld[sel]);
            check("tdata",     out_if.tdata,  act ? src_data[sel] : '0);
            check("tid",       out_if.tid,    act ? src_tid[sel]  : '0);
            check("tlast",     out_if.tlast,  act ? src_last[sel] : 1'b0);
            check("tkeep",     out_if.tkeep,  act ? src_keep[sel] : '0);
            check("tdest",     out_if.tdest,  act ? src_dest[sel] : '0);
            check("tuser",     out_if.tuser,  act ? src_user[sel] : '0);
            check("in_tready", o_rdy,         e_rdy);
            check("grant_vld", grant_vld,     act);
            if (act)
                check("grant_idx", grant_idx, sel);
`ifdef AXIS_ARB_PKT_CNT_EN
            for (int i = 0; i < N; i++)
                check($sformatf("pkt_cnt%0d", i), pkt_cnt[i], m_cnt[i]);
`endif
        end
        @(posedge clk);
        if (rst) begin
            m_owner = -1;
            m_rr    = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (hs) begin
            void'(q[sel].pop_front());
            if (src_last[sel]) begin
                m_owner = -1;
                m_rr    = (sel + 1) % N;
                if (m_cnt[sel] < (1 << CW) - 1) m_cnt[sel]++;
            end else begin
                m_owner = sel;
            end
        end else if (act) begin
            m_owner = sel;
        end
        #1;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((pending() || m_owner >= 0) && n < limit) begin
            cycle(1);
            n++;
        end
        check("drain_timeout", n >= limit, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;

        // Power-up reset: first cycle state is unknown, later ones are checked.
        rst = 1'b1;
        cycle(0);
        cycle(1);
        rst = 1'b0;
        cycle(1);

        // Header on in[2], zero-latency forward then locked body.
        dn_rdy = 1'b1;
        push_pkt(2, 3, HDR);
        drain(20);

        // Simultaneous headers on in[0] and in[3] from rr_ptr=0.
        do_reset();
        push_pkt(0, 3, HDR);
        push_pkt(3, 3, HDR);
        drain(20);
        // rr_ptr now 4: in[4] must beat in[0].
        push_pkt(0, 1, HDR);
        push_pkt(4, 1, HDR);
        drain(10);

        // Stalled header on in[1] must not be preempted by a later in[0] header.
        dn_rdy = 1'b0;
        push_pkt(1, 2, HDR);
        cycle(1);
        push_pkt(0, 2, HDR);
        cycle(1);
        cycle(1);
        dn_rdy = 1'b1;
        drain(20);

        // Single-beat packet on in[4] wraps the pointer to 0.
        do_reset();
        push_pkt(3, 1, HDR);
        drain(5);
        push_pkt(4, 1, HDR);
        drain(5);
        push_pkt(0, 1, HDR);
        push_pkt(1, 1, HDR);
        drain(10);

        // Non-header beat is never forwarded.
        push_pkt(1, 1, 4'h3);
        repeat (4) cycle(1);
        q[1].delete();
        cycle(1);

        // Reset in the middle of a packet on in[3].
        push_pkt(3, 3, HDR);
        cycle(1);
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        q[3].delete();
        cycle(1);
        push_pkt(3, 2, HDR);
        push_pkt(3, 3, HDR);
        drain(20);
`ifdef AXIS_ARB_PKT_CNT_EN
        check("pkt_cnt3_after_two", pkt_cnt[3], 16'd2);
`endif

        // Randomized traffic with random downstream backpressure.
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < N; i++)
                if (q[i].size() == 0 && $urandom_range(0, 3) == 0)
                    push_pkt(i, $urandom_range(1, 4), HDR);
            dn_rdy = ($urandom_range(0, 3) != 0);
            cycle(1);
        end
        dn_rdy = 1'b1;
        drain(500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
